// File: rtl/imem_server_pkg.sv
// Shared constants and types for the multi-thread instruction memory and its program loader.
package imem_server_pkg;

    localparam int unsigned IMEM_NUM_THREADS = 4;
    localparam int unsigned IMEM_DEPTH       = 1024;
    localparam int unsigned IMEM_DATA_W      = 32;

    // addi x0, x0, 0
    localparam logic [IMEM_DATA_W-1:0] INS_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_server_loader.sv
// Program-load engine: streams words into the instruction memory and holds the core in reset while loading.
module imem_loader
    import imem_server_pkg::*;
#(
    parameter int unsigned DEPTH  = IMEM_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [IMEM_DATA_W-1:0] ld_data,
    input  logic                   ld_last,
    output logic                   ld_ready,
    output logic                   ld_done,
    output logic                   ld_err,
    output logic                   core_rst_o,
    output imem_state_t            state_o,
    output logic                   wr_en_c,
    output logic [ADDR_W-1:0]      wr_addr_c,
    output logic [IMEM_DATA_W-1:0] wr_data_c
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    imem_state_t      r_state;
    imem_state_t      w_state_nxt;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] w_wptr_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_ready;
    logic             r_done;
    logic             r_core_rst;

    // State register plus outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wptr     <= '0;
            r_err      <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_core_rst <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_wptr     <= w_wptr_nxt;
            r_err      <= w_err_nxt;
            r_ready    <= (w_state_nxt == LOAD);
            r_done     <= (w_state_nxt == DRAIN);
            r_core_rst <= (w_state_nxt != RUN);
        end
    end

    // Next-state, pointer and write-strobe logic; pointer saturates at DEPTH
    always_comb begin
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_err_nxt   = r_err;
        wr_en_c     = 1'b0;
        unique case (r_state)
            RUN: begin
                if (ld_start) begin
                    w_state_nxt = LOAD;
                    w_wptr_nxt  = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    if (r_wptr == PTR_FULL) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        wr_en_c    = ~rst;
                        w_wptr_nxt = r_wptr + PTR_W'(1);
                    end
                    if (ld_last) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign wr_addr_c  = r_wptr[ADDR_W-1:0];
    assign wr_data_c  = ld_data;
    assign ld_ready   = r_ready;
    assign ld_done    = r_done;
    assign ld_err     = r_err;
    assign core_rst_o = r_core_rst;
    assign state_o    = r_state;

endmodule

// File: rtl/imem_server.sv
// Multi-thread instruction memory: one registered read port per hardware thread plus a program-load engine.
module imem_server
    import imem_server_pkg::*;
#(
    parameter int unsigned NUM_THREADS = IMEM_NUM_THREADS,
    parameter int unsigned DEPTH       = IMEM_DEPTH,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pc_i  [NUM_THREADS-1:0],
    output logic [31:0]            ins_o [NUM_THREADS-1:0],
    output logic [NUM_THREADS-1:0] oob_o,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [31:0]            ld_data,
    input  logic                   ld_last,
    output logic                   ld_ready,
    output logic                   ld_done,
    output logic                   ld_err,
    output logic                   core_rst_o
);

    localparam logic [31:0] BYTE_SPAN = 32'(DEPTH * 4);

    logic [IMEM_DATA_W-1:0] r_mem [DEPTH];
    logic [31:0]            r_ins [NUM_THREADS-1:0];
    logic [NUM_THREADS-1:0] r_oob;

    logic [31:0]            w_off [NUM_THREADS-1:0];
    logic [ADDR_W-1:0]      w_idx [NUM_THREADS-1:0];
    logic [NUM_THREADS-1:0] w_oob;

    imem_state_t            w_state;
    logic                   w_wr_en;
    logic [ADDR_W-1:0]      w_wr_addr;
    logic [IMEM_DATA_W-1:0] w_wr_data;

    imem_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .ld_err     (ld_err),
        .core_rst_o (core_rst_o),
        .state_o    (w_state),
        .wr_en_c    (w_wr_en),
        .wr_addr_c  (w_wr_addr),
        .wr_data_c  (w_wr_data)
    );

    // Memory array is intentionally not reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Per-thread address decode; the two low pc bits are ignored
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            w_off[t] = pc_i[t] - BASE_ADDR;
            w_oob[t] = (w_off[t] >= BYTE_SPAN);
            w_idx[t] = w_off[t][ADDR_W+1:2];
        end
    end

    // Independent registered read ports; NOP whenever the loader owns the memory
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                r_ins[t] <= INS_NOP;
            end
            r_oob <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (w_state != RUN) begin
                    r_ins[t] <= INS_NOP;
                    r_oob[t] <= 1'b0;
                end else if (w_oob[t]) begin
                    r_ins[t] <= INS_NOP;
                    r_oob[t] <= 1'b1;
                end else begin
                    r_ins[t] <= r_mem[w_idx[t]];
                    r_oob[t] <= 1'b0;
                end
            end
        end
    end

    assign ins_o = r_ins;
    assign oob_o = r_oob;

endmodule

// File: tb/tb_imem_server.sv
// Scoreboard bench for imem_server: the driver queues expected responses, a negedge monitor compares them.
module tb_imem_server;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0050_0093;
    localparam logic [31:0] W1  = 32'h00A0_0113;
    localparam logic [31:0] W2  = 32'h0020_81B3;
    localparam logic [31:0] C0  = 32'hCAFE_0000;
    localparam logic [31:0] C1  = 32'hCAFE_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i  [3:0];
    logic [31:0] ins_o [3:0];
    logic [3:0]  oob_o;
    logic        ld_start, ld_valid, ld_last;
    logic [31:0] ld_data;
    logic        ld_ready, ld_done, ld_err, core_rst_o;

    typedef struct {
        int              cyc;
        string           name;
        bit              is_rd;
        logic [3:0][31:0] ins;
        logic [3:0]      oob;
        logic            rdy;
        logic            done;
        logic            crst;
        logic            err;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    imem_server dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .ins_o      (ins_o),
        .oob_o      (oob_o),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .ld_err     (ld_err),
        .core_rst_o (core_rst_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", n, got, want, cyc);
        end
    endtask

    // Monitor: pop every expectation due at this cycle and compare
    exp_t m;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m = q.pop_front();
            if (m.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed got=cycle %0d want=cycle %0d", m.name, cyc, m.cyc);
            end else if (m.is_rd) begin
                for (int t = 0; t < 4; t++) begin
                    chk($sformatf("%s.ins%0d", m.name, t), ins_o[t], m.ins[t]);
                    chk($sformatf("%s.oob%0d", m.name, t), 32'(oob_o[t]), 32'(m.oob[t]));
                end
            end else begin
                chk({m.name, ".ld_ready"},   32'(ld_ready),   32'(m.rdy));
                chk({m.name, ".ld_done"},    32'(ld_done),    32'(m.done));
                chk({m.name, ".core_rst_o"}, 32'(core_rst_o), 32'(m.crst));
                chk({m.name, ".ld_err"},     32'(ld_err),     32'(m.err));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_ctl(input string n, input logic r, input logic d, input logic c, input logic e);
        exp_t x;
        x.cyc = cyc + 1; x.name = n; x.is_rd = 1'b0;
        x.ins = '0; x.oob = '0;
        x.rdy = r; x.done = d; x.crst = c; x.err = e;
        q.push_back(x);
    endtask

    task automatic exp_rd(input string n, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3, input logic [3:0] o);
        exp_t x;
        x.cyc = cyc + 1; x.name = n; x.is_rd = 1'b1;
        x.ins = {a3, a2, a1, a0}; x.oob = o;
        x.rdy = 1'b0; x.done = 1'b0; x.crst = 1'b0; x.err = 1'b0;
        q.push_back(x);
    endtask

    task automatic set_pc(input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3);
        pc_i[0] = a0; pc_i[1] = a1; pc_i[2] = a2; pc_i[3] = a3;
    endtask

    initial begin
        rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
        set_pc(0, 0, 0, 0);
        step();
        exp_ctl("reset", 0, 0, 1, 0);
        exp_rd("reset", NOP, NOP, NOP, NOP, 4'b0000);
        step();
        rst = 1'b0;
        exp_ctl("post_rst", 0, 0, 0, 0);
        step();

        // Three-word load
        ld_start = 1'b1; exp_ctl("start", 1, 0, 1, 0); step();
        ld_start = 1'b0; ld_valid = 1'b1;
        ld_data = W0; exp_ctl("w0", 1, 0, 1, 0); step();
        ld_data = W1; exp_ctl("w1", 1, 0, 1, 0); step();
        ld_data = W2; ld_last = 1'b1; exp_ctl("w2_drain", 0, 1, 1, 0); step();
        ld_valid = 1'b0; ld_last = 1'b0;
        set_pc(32'h0, 32'h4, 32'h8, 32'h0);
        exp_ctl("run", 0, 0, 0, 0);
        exp_rd("drain_rd", NOP, NOP, NOP, NOP, 4'b0000);
        step();
        exp_rd("rd3", W0, W1, W2, W0, 4'b0000); step();
        pc_i[2] = 32'h1000;
        exp_rd("oob2", W0, W1, NOP, W0, 4'b0100); step();

        // Overflow load: 1025 words, last one dropped
        ld_start = 1'b1; exp_ctl("ov_start", 1, 0, 1, 0); step();
        ld_start = 1'b0; ld_valid = 1'b1;
        for (int i = 0; i < 1025; i++) begin
            ld_data = 32'h1000_0000 + 32'(i);
            ld_last = (i == 1024);
            if (i == 1023) exp_ctl("ov_w1023", 1, 0, 1, 0);
            if (i == 1024) exp_ctl("ov_drop", 0, 1, 1, 1);
            step();
        end
        ld_last = 1'b0; ld_data = 32'hDEAD_BEEF;
        set_pc(32'hFFC, 32'h0, 32'h800, 32'h1000);
        exp_rd("ov_drain_rd", NOP, NOP, NOP, NOP, 4'b0000);
        exp_ctl("ov_run", 0, 0, 0, 1);
        step();
        exp_rd("ov_rd", 32'h1000_03FF, 32'h1000_0000, 32'h1000_0200, NOP, 4'b1000);
        exp_ctl("ov_sticky", 0, 0, 0, 1);
        step();

        // Load aborted by reset after two words; start+valid in RUN writes nothing
        ld_data = 32'hBAD0_BAD0; ld_start = 1'b1;
        set_pc(0, 0, 0, 0);
        exp_ctl("rs_start", 1, 0, 1, 0);
        exp_rd("rs_pre", 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000, 4'b0000);
        step();
        ld_start = 1'b0; ld_data = C0;
        exp_ctl("rs_w0", 1, 0, 1, 0);
        exp_rd("load_nop", NOP, NOP, NOP, NOP, 4'b0000);
        step();
        ld_start = 1'b1; ld_data = C1;
        exp_ctl("rs_w1", 1, 0, 1, 0);
        exp_rd("load_nop2", NOP, NOP, NOP, NOP, 4'b0000);
        step();
        ld_start = 1'b0; ld_valid = 1'b0; rst = 1'b1;
        exp_ctl("rs_abort", 0, 0, 1, 0);
        exp_rd("rs_abort", NOP, NOP, NOP, NOP, 4'b0000);
        step();
        rst = 1'b0;
        set_pc(32'h0, 32'h4, 32'h8, 32'h1000);
        exp_ctl("rs_run", 0, 0, 0, 0);
        exp_rd("rs_rd", C0, C1, 32'h1000_0002, NOP, 4'b1000);
        step();

        step();
        step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
